// File: rtl/axis_parity_checker.sv
// AXI-Stream packet parity checker.
// Accumulates the bit parity and beat count of one slave packet, then returns a
// two-beat response frame on the master port: status code, then beat count.
//
// state | meaning
// ------+-------------------------------------------------------------
// RECV  | accepting slave beats, accumulating parity and beat count
// STAT  | status word presented on master port, waiting for accept
// CNT   | beat-count word (tlast) presented on master port, waiting
module axis_parity_checker #(
    parameter int         DATA_W     = 8,
    parameter int         CNT_W      = 16,
    parameter bit         ODD_PARITY = 1'b0,
    parameter logic [7:0] PASS_CODE  = 8'hAB,
    parameter logic [7:0] FAIL_CODE  = 8'hFF,
    parameter logic [7:0] OVF_CODE   = 8'hEE
) (
    input  logic              a_clk,
    input  logic              axis_aresetn,
    input  logic              axis_s_tvalid,
    input  logic [DATA_W-1:0] axis_s_tdata,
    input  logic              axis_s_tlast,
    output logic              axis_s_tready,
    output logic              axis_m_tvalid,
    output logic [DATA_W-1:0] axis_m_tdata,
    output logic              axis_m_tlast,
    input  logic              axis_m_tready,
    output logic              parity_err
);

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_STAT = 2'd1,
        ST_CNT  = 2'd2
    } state_t;

    state_t              state_q,    state_nxt;
    logic                acc_q,      acc_nxt;
    logic [CNT_W-1:0]    cnt_q,      cnt_nxt;
    logic                ovf_q,      ovf_nxt;
    logic                s_tready_nxt;
    logic                m_tvalid_nxt;
    logic [DATA_W-1:0]   m_tdata_nxt;
    logic                m_tlast_nxt;
    logic                perr_nxt;

    logic                s_accept;
    logic                m_accept;
    logic                par_fail;
    logic [DATA_W-1:0]   cnt_word;

    assign s_accept = axis_s_tvalid & axis_s_tready;
    assign m_accept = axis_m_tvalid & axis_m_tready;

    // Beat count resized to the response word width (zero-extend or truncate).
    generate
        if (DATA_W >= CNT_W) begin : g_cnt_ext
            assign cnt_word = DATA_W'(cnt_q);
        end else begin : g_cnt_trunc
            assign cnt_word = cnt_q[DATA_W-1:0];
        end
    endgenerate

    // State, accumulators and all registered outputs.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q       <= ST_RECV;
            acc_q         <= 1'b0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            axis_s_tready <= 1'b1;
            axis_m_tvalid <= 1'b0;
            axis_m_tdata  <= '0;
            axis_m_tlast  <= 1'b0;
            parity_err    <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            acc_q         <= acc_nxt;
            cnt_q         <= cnt_nxt;
            ovf_q         <= ovf_nxt;
            axis_s_tready <= s_tready_nxt;
            axis_m_tvalid <= m_tvalid_nxt;
            axis_m_tdata  <= m_tdata_nxt;
            axis_m_tlast  <= m_tlast_nxt;
            parity_err    <= perr_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a handshake moves it.
    always_comb begin
        state_nxt    = state_q;
        acc_nxt      = acc_q;
        cnt_nxt      = cnt_q;
        ovf_nxt      = ovf_q;
        s_tready_nxt = axis_s_tready;
        m_tvalid_nxt = axis_m_tvalid;
        m_tdata_nxt  = axis_m_tdata;
        m_tlast_nxt  = axis_m_tlast;
        perr_nxt     = 1'b0;
        par_fail     = 1'b0;

        case (state_q)
            ST_RECV: begin
                if (s_accept) begin
                    acc_nxt = acc_q ^ (^axis_s_tdata);
                    // Saturate rather than wrap; the overflow flag wins over parity.
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                    if (axis_s_tlast) begin
                        par_fail     = (acc_nxt != ODD_PARITY);
                        m_tvalid_nxt = 1'b1;
                        m_tlast_nxt  = 1'b0;
                        s_tready_nxt = 1'b0;
                        state_nxt    = ST_STAT;
                        if (ovf_nxt) begin
                            m_tdata_nxt = DATA_W'(OVF_CODE);
                            perr_nxt    = 1'b1;
                        end else if (par_fail) begin
                            m_tdata_nxt = DATA_W'(FAIL_CODE);
                            perr_nxt    = 1'b1;
                        end else begin
                            m_tdata_nxt = DATA_W'(PASS_CODE);
                        end
                    end
                end
            end
            ST_STAT: begin
                if (m_accept) begin
                    m_tdata_nxt = cnt_word;
                    m_tlast_nxt = 1'b1;
                    state_nxt   = ST_CNT;
                end
            end
            ST_CNT: begin
                if (m_accept) begin
                    m_tvalid_nxt = 1'b0;
                    m_tlast_nxt  = 1'b0;
                    m_tdata_nxt  = '0;
                    acc_nxt      = 1'b0;
                    cnt_nxt      = '0;
                    ovf_nxt      = 1'b0;
                    s_tready_nxt = 1'b1;
                    state_nxt    = ST_RECV;
                end
            end
            default: begin
                state_nxt = ST_RECV;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_parity_checker.sv
// Bench for axis_parity_checker: three instances (default, odd parity, 3-bit
// counter) share the slave stimulus and master ready; expected response beats
// are queued when a packet's last beat is driven and compared as they leave.
module tb_axis_parity_checker;

    logic       a_clk = 1'b0;
    logic       rst_n;
    logic       s_tvalid;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       m_rdy;
    logic [2:0] s_tready;
    logic [2:0] m_tvalid;
    logic [2:0] m_tlast;
    logic [2:0] perr;
    logic [7:0] m_tdata [3];

    int checks = 0;
    int errors = 0;

    always #5 a_clk = ~a_clk;

    axis_parity_checker u_def (
        .a_clk(a_clk), .axis_aresetn(rst_n),
        .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
        .axis_s_tready(s_tready[0]),
        .axis_m_tvalid(m_tvalid[0]), .axis_m_tdata(m_tdata[0]), .axis_m_tlast(m_tlast[0]),
        .axis_m_tready(m_rdy), .parity_err(perr[0])
    );

    axis_parity_checker #(.ODD_PARITY(1'b1)) u_odd (
        .a_clk(a_clk), .axis_aresetn(rst_n),
        .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
        .axis_s_tready(s_tready[1]),
        .axis_m_tvalid(m_tvalid[1]), .axis_m_tdata(m_tdata[1]), .axis_m_tlast(m_tlast[1]),
        .axis_m_tready(m_rdy), .parity_err(perr[1])
    );

    axis_parity_checker #(.CNT_W(3)) u_c3 (
        .a_clk(a_clk), .axis_aresetn(rst_n),
        .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
        .axis_s_tready(s_tready[2]),
        .axis_m_tvalid(m_tvalid[2]), .axis_m_tdata(m_tdata[2]), .axis_m_tlast(m_tlast[2]),
        .axis_m_tready(m_rdy), .parity_err(perr[2])
    );

    // Packet record: beat b is data[8*b +: 8]; s*/c* are status/count words for
    // default, odd-parity and CNT_W=3 instances (odd count equals default count).
    typedef struct packed {
        logic [3:0]  n;
        logic [79:0] data;
        logic [7:0]  s0;
        logic [7:0]  c0;
        logic [7:0]  s1;
        logic [7:0]  s3;
        logic [7:0]  c3;
    } vec_t;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d3;
        logic       last;
        logic [2:0] perr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_v;
    logic perr_follow;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Master-side monitor: parity_err pulse on status entry, then beat compare on accept.
    always @(negedge a_clk) begin
        if (!rst_n) begin
            prev_v      <= 1'b0;
            perr_follow <= 1'b0;
        end else begin
            perr_follow <= 1'b0;
            if (perr_follow) chk("perr_one_cycle", {29'd0, perr}, 32'd0);
            if (m_tvalid[0] && !prev_v) begin
                if (sb.size() == 0) fail_now("unexpected_status");
                else chk("perr_pulse", {29'd0, perr}, {29'd0, sb[0].perr});
                perr_follow <= 1'b1;
            end
            if (m_tvalid[0] && m_rdy) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    mon_e = sb.pop_front();
                    chk("m_tvalid_all", {29'd0, m_tvalid}, 32'd7);
                    chk("tdata_default", {24'd0, m_tdata[0]}, {24'd0, mon_e.d0});
                    chk("tdata_odd", {24'd0, m_tdata[1]}, {24'd0, mon_e.d1});
                    chk("tdata_cnt3", {24'd0, m_tdata[2]}, {24'd0, mon_e.d3});
                    chk("tlast", {29'd0, m_tlast}, {29'd0, {3{mon_e.last}}});
                end
            end
            prev_v <= m_tvalid[0];
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.d0 = v.s0; e.d1 = v.s1; e.d3 = v.s3; e.last = 1'b0;
        e.perr = {v.s3 != 8'hAB, v.s1 != 8'hAB, v.s0 != 8'hAB};
        sb.push_back(e);
        e.d0 = v.c0; e.d1 = v.c0; e.d3 = v.c3; e.last = 1'b1; e.perr = 3'b000;
        sb.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic last);
        int t = 0;
        logic acc;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
        do begin
            @(negedge a_clk);
            acc = s_tready[0];
            @(posedge a_clk); #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) fail_now("s_accept_timeout");
        s_tvalid = 1'b0; s_tdata = 8'($urandom); s_tlast = 1'($urandom);
    endtask

    task automatic send_pkt(input vec_t v);
        for (int b = 0; b < int'(v.n); b++) begin
            repeat ($urandom_range(0, 2)) begin
                s_tvalid = 1'b0; s_tdata = 8'($urandom); s_tlast = 1'($urandom);
                @(posedge a_clk); #1;
            end
            if (b == int'(v.n) - 1) push_exp(v);
            send_beat(v.data[8*b +: 8], b == int'(v.n) - 1);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || !s_tready[0]) && t < 200) begin
            @(negedge a_clk);
            t++;
        end
        if (t >= 200) fail_now("idle_timeout");
        @(posedge a_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        vec_t v;
        int   low;

        tbl[0] = '{n: 4'd2,  data: 80'h0F03,                  s0: 8'hAB, c0: 8'h02, s1: 8'hFF, s3: 8'hAB, c3: 8'h02};
        tbl[1] = '{n: 4'd3,  data: 80'h040201,                s0: 8'hFF, c0: 8'h03, s1: 8'hAB, s3: 8'hFF, c3: 8'h03};
        tbl[2] = '{n: 4'd9,  data: 80'h0,                     s0: 8'hAB, c0: 8'h09, s1: 8'hFF, s3: 8'hEE, c3: 8'h07};
        tbl[3] = '{n: 4'd7,  data: 80'hFFFFFFFFFFFFFF,        s0: 8'hAB, c0: 8'h07, s1: 8'hFF, s3: 8'hAB, c3: 8'h07};
        tbl[4] = '{n: 4'd8,  data: 80'h0,                     s0: 8'hAB, c0: 8'h08, s1: 8'hFF, s3: 8'hEE, c3: 8'h07};
        tbl[5] = '{n: 4'd10, data: 80'hAA00FF7F3F1F0F070301,  s0: 8'hAB, c0: 8'h0A, s1: 8'hFF, s3: 8'hEE, c3: 8'h07};
        tbl[6] = '{n: 4'd9,  data: 80'h01,                    s0: 8'hFF, c0: 8'h09, s1: 8'hAB, s3: 8'hEE, c3: 8'h07};
        tbl[7] = '{n: 4'd1,  data: 80'h80,                    s0: 8'hFF, c0: 8'h01, s1: 8'hAB, s3: 8'hFF, c3: 8'h01};

        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_rdy = 1'b1;
        repeat (2) @(posedge a_clk);
        @(negedge a_clk);
        chk("rst_s_tready", {29'd0, s_tready}, 32'd7);
        chk("rst_m_tvalid", {29'd0, m_tvalid}, 32'd0);
        chk("rst_m_tlast", {29'd0, m_tlast}, 32'd0);
        chk("rst_perr", {29'd0, perr}, 32'd0);
        chk("rst_tdata", {8'd0, m_tdata[0], m_tdata[1], m_tdata[2]}, 32'd0);
        @(posedge a_clk); #1;
        rst_n = 1'b1;
        @(posedge a_clk); #1;

        for (int i = 0; i < 7; i++) begin
            send_pkt(tbl[i]);
            wait_idle();
        end

        // Single-beat packet: slave side blocked for exactly the two response cycles.
        send_pkt(tbl[7]);
        low = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge a_clk);
            if (s_tready[0]) break;
            low++;
        end
        chk("s_tready_low_cycles", low, 2);
        wait_idle();

        // Backpressure on the status beat with junk slave traffic that must be ignored.
        m_rdy = 1'b0;
        send_pkt(tbl[0]);
        s_tvalid = 1'b1; s_tdata = 8'h01; s_tlast = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge a_clk);
            chk("bp_tvalid", {29'd0, m_tvalid}, 32'd7);
            chk("bp_tdata", {24'd0, m_tdata[0]}, 32'hAB);
            chk("bp_s_tready", {29'd0, s_tready}, 32'd0);
        end
        @(posedge a_clk); #1;
        s_tvalid = 1'b0;
        m_rdy = 1'b1;
        wait_idle();
        send_pkt(tbl[1]);
        wait_idle();

        // Reset while the status beat is stalled: frame is dropped immediately.
        m_rdy = 1'b0;
        send_pkt(tbl[1]);
        repeat (2) @(posedge a_clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_m_tvalid", {29'd0, m_tvalid}, 32'd0);
        chk("rst_resp_tdata", {8'd0, m_tdata[0], m_tdata[1], m_tdata[2]}, 32'd0);
        chk("rst_resp_s_tready", {29'd0, s_tready}, 32'd7);
        sb.delete();
        m_rdy = 1'b1;
        @(posedge a_clk); #1;
        rst_n = 1'b1;
        @(posedge a_clk); #1;

        // Reset mid-packet: two beats with odd residue parity, then a clean 0x03 packet.
        send_beat(8'h01, 1'b0);
        send_beat(8'h03, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pkt_s_tready", {29'd0, s_tready}, 32'd7);
        chk("rst_pkt_m_tvalid", {29'd0, m_tvalid}, 32'd0);
        @(posedge a_clk); #1;
        rst_n = 1'b1;
        @(posedge a_clk); #1;
        v = '{n: 4'd1, data: 80'h03, s0: 8'hAB, c0: 8'h01, s1: 8'hFF, s3: 8'hAB, c3: 8'h01};
        send_pkt(v);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_parity_checker.md
Name: axis_parity_checker

Overview:
Parametrised AXI-Stream packet parity checker, successor to the fixed 8-bit parity tester. Accepts one packet on the slave port and accumulates the reduction-XOR parity of every accepted beat. After tlast, emits a 2-beat response frame on the master port: status code, then beat count. Both ports use full valid/ready handshaking with backpressure.

Parameters:
DATA_W, 8, tdata width on both ports (>=8).
CNT_W, 16, beat-counter width; counter saturates at 2^CNT_W-1.
ODD_PARITY, 0, 0: pass when total bit parity is even; 1: pass when odd.
PASS_CODE, 8'hAB, status word on pass; zero-extended to DATA_W.
FAIL_CODE, 8'hFF, status word on parity fail; zero-extended to DATA_W.
OVF_CODE, 8'hEE, status word on beat-count overflow; zero-extended to DATA_W.

Ports:
a_clk  in  1  clock; all logic on rising edge.
axis_aresetn  in  1  reset; asynchronous assert, active-low.
axis_s_tvalid  in  1  slave beat valid.
axis_s_tdata  in  DATA_W  slave beat data.
axis_s_tlast  in  1  last beat of packet.
axis_s_tready  out  1  slave ready; registered.
axis_m_tvalid  out  1  master beat valid; registered.
axis_m_tdata  out  DATA_W  response word; registered.
axis_m_tlast  out  1  high on second response beat; registered.
axis_m_tready  in  1  downstream ready.
parity_err  out  1  one-cycle pulse when a FAIL_CODE or OVF_CODE status is loaded.

Behaviour:
- Reset (axis_aresetn=0, async): state=RECV, parity acc=0, count=0, ovf=0, axis_s_tready=1, axis_m_tvalid=0, axis_m_tdata=0, axis_m_tlast=0, parity_err=0. Deassertion is sampled synchronously.
- Slave accept = axis_s_tvalid & axis_s_tready. Master accept = axis_m_tvalid & axis_m_tready.
- States:
  - RECV: axis_s_tready=1, axis_m_tvalid=0. On each accept: acc ^= ^tdata; count += 1, except at 2^CNT_W-1, where count holds and ovf is set.
  - RECV on an accepted beat with tlast: use the final values (acc', count', ovf'), which include that beat. Load status into axis_m_tdata, set axis_m_tvalid=1, axis_m_tlast=0, axis_s_tready=0, go to STAT.
  - STAT: hold all master outputs stable while axis_m_tready=0. On master accept: axis_m_tdata = count zero-extended or truncated to DATA_W, axis_m_tlast=1, go to CNT.
  - CNT: hold outputs. On master accept: axis_m_tvalid=0, axis_m_tlast=0, axis_m_tdata=0, clear acc/count/ovf, axis_s_tready=1, go to RECV.
- Status selection, in priority order: ovf' -> OVF_CODE; else parity fail -> FAIL_CODE; else PASS_CODE. Parity fail means acc' != ODD_PARITY.
- parity_err pulses high for exactly one cycle, in the cycle STAT is entered, when the status is not PASS_CODE.
- Latency: tlast accepted at edge N -> status word valid after edge N. Minimum 2 response cycles, then ready for the next packet on the following cycle. No slave beats are accepted during STAT/CNT.
- Single-beat packet (tlast on first beat) is legal; count=1.
- axis_s_tvalid low mid-packet: no update; wait indefinitely.
- tvalid or tdata changes while tready=0 are ignored.
- Async reset mid-packet or mid-response: abort immediately; the partial frame is dropped and never resumed.
- Master tvalid, once asserted, never drops before its accept (AXI-S rule).

Test Plan:
- Default params. Packet 0x03, 0x0F (tlast on 2nd), m_tready=1 -> m beats 0xAB then 0x02 with tlast; parity_err stays 0.
- Packet 0x01, 0x02, 0x04 -> 0xFF, 0x03/tlast; parity_err pulses 1 cycle. Same packet with ODD_PARITY=1 -> 0xAB, 0x03.
- Single beat 0x80 with tlast, ODD_PARITY=0 -> 0xFF, 0x01; s_tready is 0 for exactly 2 cycles with m_tready=1.
- CNT_W=3, 9-beat packet of 0x00 -> 0xEE, 0x07/tlast (overflow beats fail).
- Backpressure: m_tready=0 for 5 cycles after status -> tvalid=1 and tdata=0xAB held stable for all 5 cycles; s_tready=0 throughout; next packet accepted only after the count beat is accepted.
- Drop axis_aresetn mid-packet (after 2 beats), then send 0x03 with tlast -> all outputs reset asynchronously; response is 0xAB, 0x01, with no residue from the aborted packet.
